// File: rtl/console_writer_if.sv
// Host character/clear handshake and text-buffer write port of console_writer.
// The master modport is the host side; the slave modport is console_writer.
interface console_writer_if;
  logic        char_valid;
  logic [6:0]  char_data;
  logic        char_ready;
  logic        clear_req;
  logic [10:0] address;
  logic [6:0]  char_input;
  logic        write_enable;
  logic        busy;

  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, address, char_input, write_enable, busy
  );

  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, address, char_input, write_enable, busy
  );
endinterface

// File: rtl/console_writer.sv
// Turns a host character stream into text-buffer writes. It tracks the cursor,
// interprets CR/LF/BS, and includes a full-screen clear engine.
module console_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 25,
  parameter logic [6:0]  BLANK_CHAR = 7'h20
) (
  input logic             clk_20_mhz,
  input logic             reset_n,
  console_writer_if.slave bus
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  localparam logic [6:0] CODE_BS = 7'h08;
  localparam logic [6:0] CODE_LF = 7'h0A;
  localparam logic [6:0] CODE_CR = 7'h0D;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;

  logic [ADDR_W-1:0] cursor_addr;
  logic [ROW_W-1:0]  row_next;
  logic              printable;
  logic              accept;
  logic              start_clear;

  // Ready is combinational so a clear request in the same cycle blocks acceptance.
  assign bus.char_ready = reset_n && (state == IDLE) && !bus.clear_req;

  assign accept      = bus.char_valid && bus.char_ready;
  assign printable   = (bus.char_data >= 7'h20) && (bus.char_data <= 7'h7E);
  assign cursor_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  assign row_next    = (row == LAST_ROW) ? '0 : row + ROW_W'(1);

  // A request seen in WRITE starts the clear as soon as that write completes.
  assign start_clear = bus.clear_req && (state != CLEAR);

  always_ff @(posedge clk_20_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      row              <= '0;
      col              <= '0;
      bus.address      <= '0;
      bus.char_input   <= '0;
      bus.write_enable <= 1'b0;
      bus.busy         <= 1'b0;
    end else if (start_clear) begin
      state            <= CLEAR;
      bus.address      <= '0;
      bus.char_input   <= BLANK_CHAR;
      bus.write_enable <= 1'b1;
      bus.busy         <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              state            <= WRITE;
              bus.address      <= cursor_addr;
              bus.char_input   <= bus.char_data;
              bus.write_enable <= 1'b1;
              if (col == LAST_COL) begin
                col <= '0;
                row <= row_next;
              end else begin
                col <= col + COL_W'(1);
              end
            end else begin
              case (bus.char_data)
                CODE_CR: col <= '0;
                CODE_LF: begin
                  col <= '0;
                  row <= row_next;
                end
                CODE_BS: if (col != '0) col <= col - COL_W'(1);
                default: ;
              endcase
            end
          end
        end

        WRITE: begin
          state            <= IDLE;
          bus.write_enable <= 1'b0;
        end

        CLEAR: begin
          if (bus.address == LAST_ADDR) begin
            state            <= IDLE;
            bus.write_enable <= 1'b0;
            bus.busy         <= 1'b0;
            row              <= '0;
            col              <= '0;
          end else begin
            bus.address <= bus.address + ADDR_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Randomized self-checking bench for console_writer against a cursor/queue model
// of the expected text-buffer writes.
module tb_console_writer;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 25;
  localparam int unsigned TOTAL = COLS * ROWS;
  localparam logic [6:0]  BLANK = 7'h20;

  logic clk_20_mhz;
  logic reset_n;

  console_writer_if bus();

  console_writer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .BLANK_CHAR (BLANK)
  ) dut (
    .clk_20_mhz (clk_20_mhz),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  initial clk_20_mhz = 1'b0;
  always #25 clk_20_mhz = ~clk_20_mhz;

  int n_checks = 0;
  int n_fail   = 0;
  int m_row    = 0;
  int m_col    = 0;
  int busy_cnt = 0;
  int exp_addr[$];
  int exp_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_printable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

  // Reference cursor behaviour: one expected write per printable code.
  task automatic model_char(input logic [6:0] c);
    if (is_printable(c)) begin
      exp_addr.push_back(m_row * COLS + m_col);
      exp_data.push_back(int'(c));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (c == 7'h0D) begin
      m_col = 0;
    end else if (c == 7'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (c == 7'h08) begin
      if (m_col > 0) m_col--;
    end
  endtask

  // Every observed write must match the head of the expected queue.
  always @(negedge clk_20_mhz) begin
    if (reset_n === 1'b1) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.write_enable === 1'b1) begin
        if (exp_addr.size() == 0) begin
          check("unexpected_write_addr", bus.address, 32'hFFFF_FFFF);
        end else begin
          check("write_addr", bus.address, exp_addr.pop_front());
          check("write_data", bus.char_input, exp_data.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (bus.char_ready !== 1'b1 && t < 5000) begin
      @(negedge clk_20_mhz);
      t++;
    end
    if (t >= 5000) check("ready_timeout", bus.char_ready, 1);
  endtask

  task automatic send_char(input logic [6:0] c);
    wait_ready();
    bus.char_valid = 1'b1;
    bus.char_data  = c;
    @(posedge clk_20_mhz);
    model_char(c);
    @(negedge clk_20_mhz);
    bus.char_valid = 1'b0;
    if (is_printable(c)) check("ready_after_write", bus.char_ready, 0);
    else                 check("ready_after_ctrl", bus.char_ready, 1);
  endtask

  task automatic do_clear(input bit in_write, input bit with_valid, input bit retrigger);
    int t = 0;
    if (!in_write) wait_ready();
    busy_cnt       = 0;
    bus.clear_req  = 1'b1;
    bus.char_valid = with_valid;
    bus.char_data  = 7'h5A;
    #1 check("ready_with_clear_req", bus.char_ready, 0);
    for (int a = 0; a < int'(TOTAL); a++) begin
      exp_addr.push_back(a);
      exp_data.push_back(int'(BLANK));
    end
    m_row = 0;
    m_col = 0;
    @(negedge clk_20_mhz);
    bus.clear_req  = 1'b0;
    bus.char_valid = 1'b0;
    check("busy_start", bus.busy, 1);
    while (bus.busy === 1'b1 && t < int'(3 * TOTAL)) begin
      bus.clear_req = (retrigger && t == 100);
      @(negedge clk_20_mhz);
      t++;
    end
    bus.clear_req = 1'b0;
    if (t >= int'(3 * TOTAL)) check("clear_timeout", bus.busy, 0);
    check("busy_cycles", busy_cnt, TOTAL);
    check("clear_drained", exp_addr.size(), 0);
    check("ready_after_clear", bus.char_ready, 1);
  endtask

  function automatic logic [6:0] rand_code();
    int r = $urandom_range(0, 99);
    if (r < 70) return 7'($urandom_range(32, 126));
    if (r < 78) return 7'h0D;
    if (r < 86) return 7'h0A;
    if (r < 93) return 7'h08;
    if (r < 97) return 7'($urandom_range(0, 31));
    return 7'h7F;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = '0;
    bus.clear_req  = 1'b0;
    repeat (3) @(negedge clk_20_mhz);
    check("rst_ready", bus.char_ready, 0);
    check("rst_we", bus.write_enable, 0);
    check("rst_addr", bus.address, 0);
    check("rst_data", bus.char_input, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    #1 check("ready_after_release", bus.char_ready, 1);

    // First character lands at address 0, the next at 1.
    send_char(7'h41);
    send_char(7'h61);

    // A full row wraps onto row 1; CR LF moves to row 2.
    send_char(7'h0D);
    for (int i = 0; i < int'(COLS); i++) send_char(7'($urandom_range(32, 126)));
    send_char(7'h42);
    send_char(7'h0D);
    send_char(7'h0A);
    send_char(7'h43);

    // Bottom-right corner wraps to address 0.
    for (int i = 0; i < int'(ROWS) - 3; i++) send_char(7'h0A);
    send_char(7'h0D);
    for (int i = 0; i < int'(COLS) - 1; i++) send_char(7'($urandom_range(32, 126)));
    check("cursor_corner", m_row * COLS + m_col, TOTAL - 1);
    send_char(7'h44);
    send_char(7'h45);

    // Backspaces and an ignored control code.
    send_char(7'h78);
    send_char(7'h79);
    send_char(7'h08);
    send_char(7'h08);
    send_char(7'h01);
    send_char(7'h47);

    // Clear with a colliding character and a mid-sequence retrigger.
    do_clear(1'b0, 1'b1, 1'b1);
    send_char(7'h48);

    // Clear requested while a write is in flight.
    send_char(7'h49);
    do_clear(1'b1, 1'b0, 1'b0);
    send_char(7'h4A);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 149) == 0) do_clear(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      send_char(rand_code());
    end

    // Reset in the middle of a clear aborts it.
    wait_ready();
    bus.clear_req = 1'b1;
    for (int a = 0; a <= 500; a++) begin
      exp_addr.push_back(a);
      exp_data.push_back(int'(BLANK));
    end
    @(negedge clk_20_mhz);
    bus.clear_req = 1'b0;
    repeat (500) @(negedge clk_20_mhz);
    #5 reset_n = 1'b0;
    #1;
    check("abort_we", bus.write_enable, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_addr", bus.address, 0);
    check("abort_ready", bus.char_ready, 0);
    check("abort_drained", exp_addr.size(), 0);
    exp_addr.delete();
    exp_data.delete();
    m_row = 0;
    m_col = 0;
    repeat (3) begin
      @(negedge clk_20_mhz);
      check("in_reset_we", bus.write_enable, 0);
    end
    reset_n = 1'b1;
    #1 check("ready_after_abort", bus.char_ready, 1);
    send_char(7'h46);

    repeat (4) @(negedge clk_20_mhz);
    check("final_drained", exp_addr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 25, text rows per screen; COLS*ROWS SHALL be at most 2048.
REQ-003 Parameter BLANK_CHAR, default 7'h20, code written by the clear engine.
REQ-004 clk_20_mhz  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 char_valid  input  1  host presents a character on char_data.
REQ-007 char_data  input  7  host character code.
REQ-008 char_ready  output  1  block accepts char_data this cycle.
REQ-009 clear_req  input  1  single-cycle request to blank the screen and home the cursor.
REQ-010 address  output  11  text-buffer write address (row*COLS + col); drives the adapter's address port.
REQ-011 char_input  output  7  text-buffer write data; drives the adapter's char_input port.
REQ-012 write_enable  output  1  text-buffer write strobe, one write per high cycle.
REQ-013 busy  output  1  high while the clear sequence runs.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, WRITE, CLEAR.
REQ-015 char_ready SHALL equal (state==IDLE) && !clear_req, combinationally.
REQ-016 A character is accepted on a rising edge where char_valid && char_ready; it SHALL NOT be accepted otherwise.
REQ-017 Printable code (7'h20..7'h7E) accepted in cycle N: in cycle N+1 write_enable=1, address=row*COLS+col, char_input=code (state WRITE); the cursor then advances col+1. At col==COLS-1 it wraps to col=0, row+1.
REQ-018 WRITE SHALL last exactly one cycle and then return to IDLE, giving a sustained throughput of one character per two cycles.
REQ-019 7'h0D (CR): col<=0; no write.
REQ-020 7'h0A (LF): col<=0, row+1; no write.
REQ-021 7'h08 (BS): col-1 if col>0, else unchanged; no write.
REQ-022 Any other code below 7'h20, and 7'h7F, SHALL be consumed with no write and no cursor change.
REQ-023 Row increments from ROWS-1 SHALL wrap to row 0. There is no scrolling.
REQ-024 Non-writing codes SHALL keep the FSM in IDLE, so char_ready stays high the next cycle.
REQ-025 clear_req seen in IDLE SHALL enter CLEAR on the next edge. From the following cycle, write_enable=1 and char_input=BLANK_CHAR, with address stepping 0,1,...,COLS*ROWS-1 one per cycle.
REQ-026 After the write to the last address, the FSM SHALL return to IDLE, with row=col=0 and busy=0.
REQ-027 busy SHALL be high for exactly COLS*ROWS cycles per clear.
REQ-028 clear_req asserted in WRITE SHALL be latched as pending; CLEAR starts after the current write completes.
REQ-029 clear_req asserted during CLEAR SHALL be ignored; the sequence does not restart.
REQ-030 clear_req and char_valid in the same IDLE cycle: clear wins and the character is not accepted (char_ready=0).
REQ-031 write_enable SHALL be 0 in IDLE.
REQ-032 address and char_input SHALL be registered outputs.
REQ-033 Address arithmetic SHALL be 11-bit unsigned; row*COLS+col SHALL never exceed COLS*ROWS-1.

Reset
REQ-034 reset_n=0 SHALL immediately force state=IDLE, row=col=0, address=0, char_input=0, write_enable=0, busy=0, and clear any pending clear.
REQ-035 Reset asserted mid-CLEAR or mid-WRITE SHALL abort the operation with no further writes.
REQ-036 While reset_n=0, char_ready SHALL read 0.
REQ-037 After reset_n rises, char_ready SHALL be 1 on the first clock edge if clear_req=0.

Verification
REQ-038 Reset, then send 'A' (7'h41) -> one cycle after acceptance: write_enable=1, address=0, char_input=7'h41; the next character then lands at address 1.
REQ-039 Send 80 printable characters, then 'B' -> 'B' written at address 80 (row 1, col 0); send CR LF then 'C' -> 'C' written at address 160.
REQ-040 Cursor at row 24, col 79, send 'D' then 'E' -> 'D' written at address 1999, 'E' at address 0.
REQ-041 Pulse clear_req with char_valid=1 -> char_ready=0, busy high for 2000 cycles, 2000 writes of 7'h20 to addresses 0..1999 in order; a second clear_req mid-sequence is ignored; the next character is written at address 0.
REQ-042 Assert reset_n=0 at clear address 500 -> write_enable=0 immediately and no further writes; after release, 'F' is written at address 0.
REQ-043 Cursor at col 3, send BS, BS, 7'h01, then 'G' -> no writes for the three control codes; 'G' written at col 1.
